// File: rtl/inertial_inv_bank.sv
// Multi-channel clocked delay/inverter with runtime-selectable transport or
// inertial (glitch-swallowing) behaviour; channels are fully independent.
module inertial_inv_bank #(
    parameter int WIDTH  = 4,
    parameter int DELAY  = 3,
    parameter int INVERT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             mode,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] suppressed
);

    localparam int CW = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DELAY - 1);
    localparam logic INV_BIT = (INVERT != 0);
    // Reset value is the response to in=0.
    localparam logic RST_VAL = INV_BIT;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic          target;
        logic          tail;
        logic          out_q;
        logic          supp_q;
        logic [CW-1:0] cnt;

        assign target = in[i] ^ INV_BIT;

        if (DELAY > 1) begin : g_sr
            logic [DELAY-2:0] sr;

            // History shifts on every edge so transport stays valid across mode switches.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sr <= {(DELAY - 1){RST_VAL}};
                end else begin
                    sr[0] <= target;
                    for (int j = 1; j < DELAY - 1; j++) begin
                        sr[j] <= sr[j-1];
                    end
                end
            end

            assign tail = sr[DELAY-2];
        end else begin : g_nosr
            assign tail = target;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_q  <= RST_VAL;
                cnt    <= '0;
                supp_q <= 1'b0;
            end else if (!mode) begin
                out_q  <= tail;
                cnt    <= '0;
                supp_q <= 1'b0;
            end else if (target != out_q) begin
                supp_q <= 1'b0;
                if (cnt == CNT_MAX) begin
                    out_q <= target;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                // A run that ended before reaching DELAY samples is a swallowed glitch.
                supp_q <= (cnt != '0);
                cnt    <= '0;
            end
        end

        assign out[i]        = out_q;
        assign suppressed[i] = supp_q;
    end

endmodule

// File: tb/tb_inertial_inv_bank.sv
// Bench for inertial_inv_bank: two instances (4ch/D3/inverting and 1ch/D1/buffer)
// checked every cycle against a history-based model plus literal directed checks.
module tb_inertial_inv_bank;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in_a = 4'h0;
    logic       mode_a = 1'b0;
    logic [3:0] out_a;
    logic [3:0] supp_a;
    logic [0:0] in_b = 1'b0;
    logic       mode_b = 1'b0;
    logic [0:0] out_b;
    logic [0:0] supp_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    inertial_inv_bank #(.WIDTH(4), .DELAY(3), .INVERT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in(in_a), .mode(mode_a),
        .out(out_a), .suppressed(supp_a)
    );

    inertial_inv_bank #(.WIDTH(1), .DELAY(1), .INVERT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in(in_b), .mode(mode_b),
        .out(out_b), .suppressed(supp_b)
    );

    // Model: channels 0-3 belong to dut_a, channel 4 to dut_b.
    localparam int NCH = 5;
    int   ch_d[NCH]   = '{3, 3, 3, 3, 1};
    int   ch_inv[NCH] = '{1, 1, 1, 1, 0};
    logic hist[NCH][8];
    logic m_out[NCH];
    logic m_supp[NCH];
    int   streak[NCH];

    function automatic logic ch_in(int c);
        return (c < 4) ? in_a[c] : in_b[0];
    endfunction

    function automatic logic ch_mode(int c);
        return (c < 4) ? mode_a : mode_b;
    endfunction

    // Transport: output is the target sampled DELAY-1 edges ago.
    // Inertial: output takes a new value once it has been sampled DELAY edges in a row.
    always @(posedge clk or negedge rst_n) begin
        for (int c = 0; c < NCH; c++) begin
            logic t;
            if (!rst_n) begin
                for (int j = 0; j < 8; j++) hist[c][j] = ch_inv[c][0];
                m_out[c]  = ch_inv[c][0];
                m_supp[c] = 1'b0;
                streak[c] = 0;
            end else begin
                t = ch_in(c) ^ ch_inv[c][0];
                for (int j = 7; j > 0; j--) hist[c][j] = hist[c][j-1];
                hist[c][0] = t;
                if (!ch_mode(c)) begin
                    m_out[c]  = hist[c][ch_d[c]-1];
                    m_supp[c] = 1'b0;
                    streak[c] = 0;
                end else if (t != m_out[c]) begin
                    m_supp[c] = 1'b0;
                    streak[c] = streak[c] + 1;
                    if (streak[c] == ch_d[c]) begin
                        m_out[c]  = t;
                        streak[c] = 0;
                    end
                end else begin
                    m_supp[c] = (streak[c] != 0);
                    streak[c] = 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [3:0] eo;
        logic [3:0] es;
        for (int c = 0; c < 4; c++) begin
            eo[c] = m_out[c];
            es[c] = m_supp[c];
        end
        check("model_out_a", {28'h0, out_a}, {28'h0, eo});
        check("model_supp_a", {28'h0, supp_a}, {28'h0, es});
        check("model_out_b", {31'h0, out_b}, {31'h0, m_out[4]});
        check("model_supp_b", {31'h0, supp_b}, {31'h0, m_supp[4]});
    end

    task automatic tick();
        @(negedge clk);
        in_b   = 1'($urandom_range(0, 1));
        mode_b = 1'($urandom_range(0, 1));
    endtask

    task automatic lit(input string name, input logic [3:0] eo, input logic [3:0] es);
        check({name, "_out"}, {28'h0, out_a}, {28'h0, eo});
        check({name, "_supp"}, {28'h0, supp_a}, {28'h0, es});
    endtask

    initial begin
        // Reset and idle
        repeat (3) tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            lit("idle", 4'hF, 4'h0);
        end

        // Transport step 0 -> 5
        in_a = 4'h5;
        tick(); lit("tstep_k", 4'hF, 4'h0);
        tick(); lit("tstep_k1", 4'hF, 4'h0);
        tick(); lit("tstep_k2", 4'hA, 4'h0);

        // Transport one-cycle glitch on ch0
        in_a = 4'h0;
        repeat (4) tick();
        in_a = 4'h1;
        tick(); lit("tglitch_k", 4'hF, 4'h0);
        in_a = 4'h0;
        tick(); lit("tglitch_k1", 4'hF, 4'h0);
        tick(); lit("tglitch_k2", 4'hE, 4'h0);
        tick(); lit("tglitch_k3", 4'hF, 4'h0);

        // Inertial filter on ch1
        mode_a = 1'b1;
        tick(); lit("isw", 4'hF, 4'h0);
        in_a = 4'h2;
        tick(); tick(); lit("i2_hold", 4'hF, 4'h0);
        in_a = 4'h0;
        tick(); lit("i2_supp", 4'hF, 4'h2);
        tick(); lit("i2_after", 4'hF, 4'h0);
        in_a = 4'h2;
        tick(); tick(); lit("i3_hold", 4'hF, 4'h0);
        tick(); lit("i3_change", 4'hD, 4'h0);
        in_a = 4'h0;
        repeat (3) tick();
        lit("i3_back", 4'hF, 4'h0);

        // 0->1 switch while a transport pulse is in flight on ch2
        mode_a = 1'b0;
        repeat (3) tick();
        in_a = 4'h4;
        tick();
        in_a = 4'h0;
        mode_a = 1'b1;
        tick(); lit("sw01_k1", 4'hF, 4'h0);
        tick(); lit("sw01_k2", 4'hF, 4'h0);
        tick(); lit("sw01_k3", 4'hF, 4'h0);

        // 1->0 switch with a pending count on ch2
        in_a = 4'h4;
        tick(); tick(); lit("sw10_pend", 4'hF, 4'h0);
        mode_a = 1'b0;
        tick(); lit("sw10_tail", 4'hB, 4'h0);
        tick(); lit("sw10_next", 4'hB, 4'h0);

        // Asynchronous reset between edges, mid-pulse
        in_a = 4'h0;
        tick();
        #2 rst_n = 1'b0;
        #1 lit("async_rst", 4'hF, 4'h0);
        tick();
        rst_n = 1'b1;
        tick(); lit("post_rst", 4'hF, 4'h0);
        tick(); lit("post_rst2", 4'hF, 4'h0);

        // Random phase: sparse input flips give both short glitches and long runs
        for (int k = 0; k < 600; k++) begin
            tick();
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) in_a[b] = ~in_a[b];
            end
            if ($urandom_range(0, 15) == 0) mode_a = ~mode_a;
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        repeat (4) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
